// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and defaults for the UART transmit FIFO and its drain FSM.
package uart_tx_fifo_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } drain_state_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular byte buffer with registered full/empty/count; storage is not reset.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);

  // push is taken only while full is low and pop only while empty is low;
  // a strobe against the corresponding flag is ignored and leaves all state intact.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  // DEPTH is a power of two, so pointer overflow is the wrap to 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (PW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of an async_transmitter, drained one byte per busy cycle.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = ptr_width(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  input  logic             ovf_clr,
  input  logic             TxD_busy,
  output logic             TxD_start,
  output logic [WIDTH-1:0] TxD_data,
  output drain_state_e     dbg_state
);

  drain_state_e     state_q, state_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] head_data;
  logic             drop;

  // The head is popped during the start cycle, so the byte is still counted
  // while TxD_start is high and empty never coincides with the pulse.
  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (start_q),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign drop = wr_en & full;

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    data_d     = data_q;
    overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
    case (state_q)
      IDLE: begin
        if (!empty && !TxD_busy) begin
          start_d = 1'b1;
          data_d  = head_data;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (TxD_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!TxD_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign TxD_start = start_q;
  assign TxD_data  = data_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple busy-counter transmitter model.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [7:0]   wr_data = 8'h00;
  logic         ovf_clr = 1'b0;
  logic         TxD_busy;
  logic         full, empty, overflow, TxD_start;
  logic [4:0]   count;
  logic [7:0]   TxD_data;
  drain_state_e dbg_state;

  int         vectors = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         start_cnt = 0;
  logic       prev_start = 1'b0;
  logic [7:0] last_tx = 8'h00;
  int         s0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // transmitter model: busy for busy_len cycles after each start, or forced high
  bit force_busy = 1'b0;
  int busy_len = 3;
  int busy_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            busy_cnt <= 0;
    else if (TxD_start)    busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign TxD_busy = force_busy | (busy_cnt != 0);

  uart_tx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .TxD_busy  (TxD_busy),
    .TxD_start (TxD_start),
    .TxD_data  (TxD_data),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_count"}, 32'(count), 0);
    chk({p, "_empty"}, 32'(empty), 1);
    chk({p, "_full"}, 32'(full), 0);
    chk({p, "_overflow"}, 32'(overflow), 0);
    chk({p, "_start"}, 32'(TxD_start), 0);
    chk({p, "_data"}, 32'(TxD_data), 0);
    chk({p, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // driver: called at a negedge, holds wr_en across one rising edge
  task automatic wr(input logic [7:0] b, input bit acc);
    wr_en = 1'b1;
    wr_data = b;
    if (acc) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(empty && dbg_state == IDLE && !TxD_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 1);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!TxD_start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("start_timeout", 32'(TxD_start), 1);
  endtask

  task automatic wait_state(input drain_state_e st, input int budget);
    int n = 0;
    while (dbg_state != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("state_timeout", 32'(dbg_state), 32'(st));
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (TxD_start) begin
        start_cnt++;
        chk("start_while_busy", 32'(TxD_busy), 0);
        chk("start_while_empty", 32'(empty), 0);
        chk("start_width", 32'(prev_start), 0);
        chk("tx_queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("tx_byte", 32'(TxD_data), 32'(exp_q.pop_front()));
        last_tx = TxD_data;
      end else begin
        chk("tx_data_hold", 32'(TxD_data), 32'(last_tx));
      end
      prev_start = TxD_start;
    end else begin
      prev_start = 1'b0;
      last_tx = 8'h00;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    #2 rst_n = 1'b1;
    @(negedge clk);

    // three bytes back to back, transmitter idle
    busy_len = 3;
    wr(8'h41, 1'b1);
    wr(8'h42, 1'b1);
    wr(8'h43, 1'b1);
    wait_drain(200);
    chk("abc_empty", 32'(empty), 1);
    chk("abc_left", 32'(exp_q.size()), 0);
    chk("abc_starts", 32'(start_cnt), 3);

    // fill while busy, 17th write dropped
    force_busy = 1'b1;
    for (int i = 0; i < 15; i++) wr(8'(i), 1'b1);
    chk("fill15_full", 32'(full), 0);
    chk("fill15_count", 32'(count), 15);
    wr(8'h0f, 1'b1);
    chk("fill16_full", 32'(full), 1);
    chk("fill16_count", 32'(count), 16);
    chk("fill16_ovf", 32'(overflow), 0);
    wr(8'h10, 1'b0);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_count", 32'(count), 16);
    chk("drop_full", 32'(full), 1);

    // clear loses to a simultaneous drop, then clears alone
    ovf_clr = 1'b1;
    wr(8'h11, 1'b0);
    ovf_clr = 1'b0;
    chk("clr_vs_drop", 32'(overflow), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("clr_alone", 32'(overflow), 0);
    chk("clr_count", 32'(count), 16);

    // write while full during a pop is dropped; at 15 write+pop holds count
    busy_len = 4;
    force_busy = 1'b0;
    wait_start(20);
    wr(8'hee, 1'b0);
    chk("pop_drop_ovf", 32'(overflow), 1);
    chk("pop_drop_count", 32'(count), 15);
    wait_start(50);
    wr(8'ha0, 1'b1);
    chk("wr_pop_count", 32'(count), 15);
    busy_len = 2;
    wait_drain(1000);
    chk("full_drain_left", 32'(exp_q.size()), 0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;

    // reset during WAIT_DONE
    busy_len = 10;
    wr(8'h55, 1'b1);
    wait_state(WAIT_DONE, 50);
    chk("r55_sent", 32'(exp_q.size()), 0);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_wd");
    @(negedge clk);
    #2 rst_n = 1'b1;
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    chk("no_start_after_rst", 32'(start_cnt), 32'(s0));

    // first start after reset waits for busy low
    force_busy = 1'b1;
    wr(8'h66, 1'b1);
    repeat (5) @(negedge clk);
    chk("busy_hold_starts", 32'(start_cnt), 32'(s0));
    chk("busy_hold_count", 32'(count), 1);
    force_busy = 1'b0;
    wait_drain(100);
    chk("r66_starts", 32'(start_cnt), 32'(s0 + 1));
    chk("r66_left", 32'(exp_q.size()), 0);

    // reset cuts a start pulse asynchronously
    busy_len = 3;
    wr(8'h77, 1'b1);
    wait_start(20);
    #2 rst_n = 1'b0;
    #1 chk("cut_start", 32'(TxD_start), 0);
    chk("cut_count", 32'(count), 0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 20 bytes trickled in while draining at busy length 10; pointers wrap
    busy_len = 10;
    s0 = start_cnt;
    for (int i = 0; i < 20; i++) begin
      wr(8'h80 + 8'(i), 1'b1);
      repeat (3) @(negedge clk);
    end
    chk("wrap_ovf", 32'(overflow), 0);
    wait_drain(1000);
    chk("wrap_left", 32'(exp_q.size()), 0);
    chk("wrap_starts", 32'(start_cnt), 32'(s0 + 20));
    chk("wrap_empty", 32'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
